imm_extend_pipe: RTL and testbench

//  Parametrised, registered immediate-extension stage for the pipelined core; sits between decode and execute.

---
 rtl/imm_extend_pipe_pkg.sv | 22 ++
 rtl/imm_extend_pipe_if.sv | 29 ++
 rtl/imm_extend_pipe_format.sv | 40 ++++
 rtl/imm_extend_pipe.sv | 119 +++++++++++
 tb/tb_imm_extend_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared types and default widths for the registered immediate-extension stage.
package imm_extend_pipe_pkg;

    typedef enum logic [1:0] {
        IMM_DP     = 2'd0,
        IMM_MEM    = 2'd1,
        IMM_BR     = 2'd2,
        IMM_PREFIX = 2'd3
    } imm_src_t;

    typedef enum logic {
        S_NORM   = 1'b0,
        S_PREFIX = 1'b1
    } ext_state_t;

    localparam int DEF_IMM_W    = 19;
    localparam int DEF_OUT_W    = 24;
    localparam int DEF_DP_W     = 7;
    localparam int DEF_MEM_W    = 7;
    localparam int DEF_BR_SHIFT = 0;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-side input handshake, execute-side output handshake and prefix status.
interface imm_extend_pipe_if #(
    parameter int IMM_W = imm_extend_pipe_pkg::DEF_IMM_W,
    parameter int OUT_W = imm_extend_pipe_pkg::DEF_OUT_W
);
    import imm_extend_pipe_pkg::*;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IMM_W-1:0] imm;
    imm_src_t         imm_src;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic             prefix_pending;
    logic             prefix_overrun;

    modport master (
        output flush, in_valid, imm, imm_src, out_ready,
        input  in_ready, out_valid, out_imm, prefix_pending, prefix_overrun
    );

    modport slave (
        input  flush, in_valid, imm, imm_src, out_ready,
        output in_ready, out_valid, out_imm, prefix_pending, prefix_overrun
    );

endinterface

// File: rtl/imm_extend_pipe_format.sv
// Combinational immediate formatter: zero-extended DP/MEM fields with optional
// high-order prefix, sign-extended and shifted branch offsets.
module imm_extend_pipe_format
    import imm_extend_pipe_pkg::*;
#(
    parameter int IMM_W    = DEF_IMM_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int DP_W     = DEF_DP_W,
    parameter int MEM_W    = DEF_MEM_W,
    parameter int BR_SHIFT = DEF_BR_SHIFT
) (
    input  logic [IMM_W-1:0] imm,
    input  imm_src_t         imm_src,
    input  logic [IMM_W-1:0] prefix,
    input  logic             pfx_en,
    output logic [OUT_W-1:0] value
);

    logic [OUT_W-1:0] pfx_ext;
    logic [OUT_W-1:0] dp_field;
    logic [OUT_W-1:0] mem_field;
    logic [OUT_W-1:0] br_sext;

    // Shifting the zero-extended prefix up by the field width keeps exactly
    // prefix[OUT_W-W-1:0] and zero-fills when the prefix is narrower.
    always_comb begin
        pfx_ext   = pfx_en ? OUT_W'(prefix) : '0;
        dp_field  = OUT_W'(imm[DP_W-1:0]);
        mem_field = OUT_W'(imm[MEM_W-1:0]);
        br_sext   = OUT_W'($signed(imm));
        value     = '0;
        unique case (imm_src)
            IMM_DP:  value = (pfx_ext << DP_W) | dp_field;
            IMM_MEM: value = (pfx_ext << MEM_W) | mem_field;
            IMM_BR:  value = br_sext << BR_SHIFT;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage between decode and execute, with a
// two-instruction PREFIX mechanism for wide DP/MEM constants.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_NORM   | no prefix latched; DP/MEM upper bits are zero
//   S_PREFIX | prefix latched, waiting for its DP/MEM user
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int IMM_W    = DEF_IMM_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int DP_W     = DEF_DP_W,
    parameter int MEM_W    = DEF_MEM_W,
    parameter int BR_SHIFT = DEF_BR_SHIFT
) (
    input  logic           clk,
    input  logic           reset,
    imm_extend_pipe_if.slave bus
);

    if (IMM_W < DP_W || IMM_W < MEM_W || OUT_W < IMM_W + BR_SHIFT) begin : g_param_check
        $error("imm_extend_pipe: illegal width parameters");
    end

    ext_state_t       state;
    ext_state_t       state_nxt;
    logic [IMM_W-1:0] prefix_q;
    logic [OUT_W-1:0] fmt_value;
    logic             accept;
    logic             load_out;
    logic             latch_load;
    logic             latch_clear;
    logic             overrun_nxt;
    logic             pfx_en;

    assign bus.in_ready       = !reset && (!bus.out_valid || bus.out_ready);
    assign accept             = bus.in_valid && bus.in_ready;
    assign pfx_en             = (state == S_PREFIX);
    assign bus.prefix_pending = (state == S_PREFIX);

    imm_extend_pipe_format #(
        .IMM_W    (IMM_W),
        .OUT_W    (OUT_W),
        .DP_W     (DP_W),
        .MEM_W    (MEM_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_format (
        .imm     (bus.imm),
        .imm_src (bus.imm_src),
        .prefix  (prefix_q),
        .pfx_en  (pfx_en),
        .value   (fmt_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_NORM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = S_NORM;
        end else if (accept) begin
            state_nxt = (bus.imm_src == IMM_PREFIX) ? S_PREFIX : S_NORM;
        end
    end

    // Flush wins over any accept in the same cycle and never reports overrun.
    always_comb begin
        load_out    = 1'b0;
        latch_load  = 1'b0;
        latch_clear = 1'b0;
        overrun_nxt = 1'b0;
        if (bus.flush) begin
            latch_clear = 1'b1;
        end else if (accept) begin
            if (bus.imm_src == IMM_PREFIX) begin
                latch_load  = 1'b1;
                overrun_nxt = (state == S_PREFIX);
            end else begin
                load_out    = 1'b1;
                latch_clear = 1'b1;
                overrun_nxt = (state == S_PREFIX) && (bus.imm_src == IMM_BR);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid      <= 1'b0;
            bus.out_imm        <= '0;
            bus.prefix_overrun <= 1'b0;
            prefix_q           <= '0;
        end else begin
            bus.prefix_overrun <= overrun_nxt;

            if (latch_clear) begin
                prefix_q <= '0;
            end else if (latch_load) begin
                prefix_q <= bus.imm;
            end

            if (bus.flush) begin
                bus.out_valid <= 1'b0;
            end else if (load_out) begin
                bus.out_valid <= 1'b1;
                bus.out_imm   <= fmt_value;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed scenarios plus a randomized
// run against a behavioural reference model.
module tb_imm_extend_pipe;
    import imm_extend_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IMM_W(19), .OUT_W(24)) bus ();
    imm_extend_pipe_if #(.IMM_W(19), .OUT_W(24)) bus2 ();

    imm_extend_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    imm_extend_pipe #(.BR_SHIFT(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // Reference formatting from arithmetic on the field rules.
    function automatic logic [23:0] model_fmt(imm_src_t src, int unsigned im, bit pend,
                                              int unsigned pfx, int sh);
        longint v;
        v = 0;
        case (src)
            IMM_DP, IMM_MEM: v = longint'(pend ? (pfx % (1 << 17)) : 0) * 128 + longint'(im % 128);
            IMM_BR: begin
                v = (im >= (1 << 18)) ? longint'(im) - (longint'(1) << 19) : longint'(im);
                v = v * (longint'(1) << sh);
            end
            default: v = 0;
        endcase
        return 24'(v);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(imm_src_t s, logic [18:0] v);
        bus.in_valid = 1'b1;
        bus.imm_src  = s;
        bus.imm      = v;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_imm !== 24'h0) begin
            n_fail++; $display("FAIL reset_out: got v=%b imm=%h want v=0 imm=000000", bus.out_valid, bus.out_imm);
        end
        n_checks++;
        if (bus.prefix_pending !== 1'b0 || bus.prefix_overrun !== 1'b0) begin
            n_fail++; $display("FAIL reset_prefix: got pend=%b ovr=%b want 0 0", bus.prefix_pending, bus.prefix_overrun);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
        cyc();
    endtask

    task automatic test_dp_mem();
        send(IMM_DP, 19'h7FFFF);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== 24'h00007F) begin
            n_fail++; $display("FAIL dp_field: got v=%b imm=%h want v=1 imm=00007f", bus.out_valid, bus.out_imm);
        end
        send(IMM_MEM, 19'h00012);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== 24'h000012) begin
            n_fail++; $display("FAIL mem_field: got v=%b imm=%h want v=1 imm=000012", bus.out_valid, bus.out_imm);
        end
        cyc();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_branch();
        send(IMM_BR, 19'h40000);
        n_checks++;
        if (bus.out_imm !== 24'hFC0000) begin
            n_fail++; $display("FAIL br_neg: got %h want fc0000", bus.out_imm);
        end
        send(IMM_BR, 19'h00005);
        n_checks++;
        if (bus.out_imm !== 24'h000005) begin
            n_fail++; $display("FAIL br_pos: got %h want 000005", bus.out_imm);
        end
        bus2.in_valid = 1'b1;
        bus2.imm_src  = IMM_BR;
        bus2.imm      = 19'h7FFFF;
        cyc();
        n_checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_imm !== 24'hFFFFFC) begin
            n_fail++; $display("FAIL br_shift2_m1: got v=%b imm=%h want v=1 imm=fffffc", bus2.out_valid, bus2.out_imm);
        end
        bus2.imm = 19'h40000;
        cyc();
        n_checks++;
        if (bus2.out_imm !== model_fmt(IMM_BR, 32'h40000, 1'b0, 0, 2)) begin
            n_fail++; $display("FAIL br_shift2_min: got %h want %h", bus2.out_imm, model_fmt(IMM_BR, 32'h40000, 1'b0, 0, 2));
        end
        bus2.in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_prefix();
        send(IMM_PREFIX, 19'h1ABCD);
        n_checks++;
        if (bus.prefix_pending !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL prefix_latch: got pend=%b v=%b want pend=1 v=0", bus.prefix_pending, bus.out_valid);
        end
        send(IMM_DP, 19'h00055);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== 24'hD5E6D5) begin
            n_fail++; $display("FAIL prefix_dp: got v=%b imm=%h want v=1 imm=d5e6d5", bus.out_valid, bus.out_imm);
        end
        n_checks++;
        if (bus.prefix_pending !== 1'b0 || bus.prefix_overrun !== 1'b0) begin
            n_fail++; $display("FAIL prefix_consumed: got pend=%b ovr=%b want 0 0", bus.prefix_pending, bus.prefix_overrun);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        send(IMM_DP, 19'h00011);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== 24'h000011) begin
            n_fail++; $display("FAIL stall_load: got v=%b imm=%h want v=1 imm=000011", bus.out_valid, bus.out_imm);
        end
        bus.in_valid = 1'b1;
        bus.imm_src  = IMM_DP;
        bus.imm      = 19'h00022;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_imm !== 24'h000011 || bus.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b imm=%h want rdy=0 v=1 imm=000011",
                                   i, bus.in_ready, bus.out_valid, bus.out_imm);
            end
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready);
        end
        cyc();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== 24'h000022) begin
            n_fail++; $display("FAIL no_bubble: got v=%b imm=%h want v=1 imm=000022", bus.out_valid, bus.out_imm);
        end
        cyc();
    endtask

    task automatic test_overrun();
        send(IMM_PREFIX, 19'h00001);
        send(IMM_PREFIX, 19'h00002);
        n_checks++;
        if (bus.prefix_overrun !== 1'b1 || bus.prefix_pending !== 1'b1) begin
            n_fail++; $display("FAIL overrun_pfx: got ovr=%b pend=%b want 1 1", bus.prefix_overrun, bus.prefix_pending);
        end
        send(IMM_DP, 19'h00000);
        n_checks++;
        if (bus.out_imm !== 24'h000100 || bus.prefix_overrun !== 1'b0) begin
            n_fail++; $display("FAIL overrun_newest: got imm=%h ovr=%b want imm=000100 ovr=0", bus.out_imm, bus.prefix_overrun);
        end
        send(IMM_PREFIX, 19'h0ABCD);
        send(IMM_BR, 19'h00003);
        n_checks++;
        if (bus.prefix_overrun !== 1'b1 || bus.out_imm !== 24'h000003 || bus.prefix_pending !== 1'b0) begin
            n_fail++; $display("FAIL overrun_br: got ovr=%b imm=%h pend=%b want 1 000003 0",
                               bus.prefix_overrun, bus.out_imm, bus.prefix_pending);
        end
        cyc();
        n_checks++;
        if (bus.prefix_overrun !== 1'b0) begin
            n_fail++; $display("FAIL overrun_pulse_len: got %b want 0", bus.prefix_overrun);
        end
    endtask

    task automatic test_flush();
        send(IMM_PREFIX, 19'h00007);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.imm_src  = IMM_PREFIX;
        bus.imm      = 19'h00005;
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.prefix_pending !== 1'b0 || bus.prefix_overrun !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_drop: got pend=%b ovr=%b v=%b want 0 0 0",
                               bus.prefix_pending, bus.prefix_overrun, bus.out_valid);
        end
        send(IMM_DP, 19'h00001);
        n_checks++;
        if (bus.out_imm !== 24'h000001) begin
            n_fail++; $display("FAIL flush_after_dp: got %h want 000001", bus.out_imm);
        end
        send(IMM_PREFIX, 19'h00007);
        reset = 1'b1;
        cyc();
        n_checks++;
        if (bus.prefix_pending !== 1'b0 || bus.prefix_overrun !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got pend=%b ovr=%b rdy=%b want 0 0 0",
                               bus.prefix_pending, bus.prefix_overrun, bus.in_ready);
        end
        reset = 1'b0;
        send(IMM_DP, 19'h00001);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== 24'h000001) begin
            n_fail++; $display("FAIL reset_after_dp: got v=%b imm=%h want v=1 imm=000001", bus.out_valid, bus.out_imm);
        end
        cyc();
    endtask

    task automatic test_random();
        bit          m_ov, m_pend, m_ovr, acc, load, exp_rdy, new_ovr;
        logic [23:0] m_oi;
        int unsigned m_pfx;
        imm_src_t    src;
        int unsigned im;
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        m_ov = 0; m_pend = 0; m_ovr = 0; m_pfx = 0; m_oi = '0;
        for (int n = 0; n < 500; n++) begin
            src           = imm_src_t'(2'($urandom_range(0, 3)));
            im            = $urandom_range(0, 32'h7FFFF);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.imm_src   = src;
            bus.imm       = 19'(im);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            #1;
            exp_rdy = !m_ov || bus.out_ready;
            n_checks++;
            if (bus.in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, bus.in_ready, exp_rdy);
            end
            acc     = bus.in_valid && exp_rdy;
            new_ovr = 0;
            load    = 0;
            if (bus.flush) begin
                m_ov = 0; m_pend = 0; m_pfx = 0;
            end else begin
                if (acc) begin
                    if (src == IMM_PREFIX) begin
                        new_ovr = m_pend;
                        m_pend  = 1;
                        m_pfx   = im;
                    end else begin
                        m_oi    = model_fmt(src, im, m_pend, m_pfx, 0);
                        m_ov    = 1;
                        load    = 1;
                        new_ovr = m_pend && (src == IMM_BR);
                        m_pend  = 0;
                        m_pfx   = 0;
                    end
                end
                if (!load && bus.out_ready) m_ov = 0;
            end
            m_ovr = new_ovr;
            cyc();
            n_checks++;
            if (bus.out_valid !== m_ov || (m_ov && bus.out_imm !== m_oi)) begin
                n_fail++; $display("FAIL rnd_out[%0d]: got v=%b imm=%h want v=%b imm=%h",
                                   n, bus.out_valid, bus.out_imm, m_ov, m_oi);
            end
            n_checks++;
            if (bus.prefix_pending !== m_pend || bus.prefix_overrun !== m_ovr) begin
                n_fail++; $display("FAIL rnd_prefix[%0d]: got pend=%b ovr=%b want pend=%b ovr=%b",
                                   n, bus.prefix_pending, bus.prefix_overrun, m_pend, m_ovr);
            end
        end
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
    endtask

    initial begin
        reset          = 1'b1;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.imm        = '0;
        bus.imm_src    = IMM_DP;
        bus.out_ready  = 1'b1;
        bus2.flush     = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.imm       = '0;
        bus2.imm_src   = IMM_DP;
        bus2.out_ready = 1'b1;

        test_reset();
        test_dp_mem();
        test_branch();
        test_prefix();
        test_back_to_back();
        test_overrun();
        test_flush();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
